gerenciador_partida_drone: RTL and testbench

Parametrised game-session controller for the drone simulator. It handles the menu, gameplay and game-over phases:
- Menu: mode selection, then lives selection, both driven by controle_vertical and confirma.
- Gameplay: progress counting on game ticks, collision handling with a post-hit invulnerability window, and win/lose detection.
- It generalises the fixed mode and lives handling of simulador_drone to N_MODOS modes and MAX_VIDAS lives, and adds invulnerability and a mode-scaled goal.
- It sits between the user controls and the datapath; the obstacle/collision checker and the game tick divider feed it.

---
 rtl/pkg_drone.sv | 18 +
 rtl/detector_borda.sv | 20 ++
 rtl/gerenciador_partida_drone.sv | 154 +++++++++++++++
 tb/tb_gerenciador_partida_drone.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pkg_drone.sv
// Shared state codes and controle_vertical encodings for the drone game-session controller.
package pkg_drone;

  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    ESPERA_MODO  = 4'd1,
    ESPERA_VIDAS = 4'd2,
    JOGANDO      = 4'd3,
    INVULNERAVEL = 4'd4,
    VENCEU       = 4'd5,
    PERDEU       = 4'd6
  } estado_t;

  localparam logic [1:0] CV_NADA  = 2'b00;
  localparam logic [1:0] CV_SOBE  = 2'b01;
  localparam logic [1:0] CV_DESCE = 2'b10;

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector: each bit pulses for one cycle when its level goes 0 -> 1.
module detector_borda #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] nivel_i,
  output logic [WIDTH-1:0] borda_o
);

  logic [WIDTH-1:0] hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hist_q <= '0;
    else         hist_q <= nivel_i;
  end

  assign borda_o = nivel_i & ~hist_q;

endmodule

// File: rtl/gerenciador_partida_drone.sv
// Game-session controller: menu (mode/lives), gameplay with invulnerability window, win/lose.
module gerenciador_partida_drone
  import pkg_drone::*;
#(
  parameter int unsigned N_MODOS   = 3,
  parameter int unsigned MAX_VIDAS = 5,
  parameter int unsigned META_BASE = 32,
  parameter int unsigned T_INVULN  = 8
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  iniciar,
  input  logic [1:0]                            controle_vertical,
  input  logic                                  confirma,
  input  logic                                  tick,
  input  logic                                  colisao,
  output logic [((N_MODOS > 1) ? $clog2(N_MODOS) : 1)-1:0] modo,
  output logic [$clog2(MAX_VIDAS+1)-1:0]        vidas,
  output logic [$clog2(META_BASE*N_MODOS+1)-1:0] progresso,
  output logic                                  jogando,
  output logic                                  invulneravel,
  output logic                                  venceu,
  output logic                                  perdeu,
  output logic [3:0]                            db_estado
);

  localparam int unsigned MW = (N_MODOS > 1) ? $clog2(N_MODOS) : 1;
  localparam int unsigned VW = $clog2(MAX_VIDAS+1);
  localparam int unsigned PW = $clog2(META_BASE*N_MODOS+1);
  localparam int unsigned TW = $clog2(T_INVULN+1);

  estado_t         estado_q, estado_d;
  logic [MW-1:0]   modo_q, modo_d;
  logic [VW-1:0]   vidas_q, vidas_d;
  logic [PW-1:0]   progresso_q, progresso_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [2:0]      nivel, borda;
  logic            sobe, desce, conf;
  logic [PW-1:0]   meta, prog_inc;
  logic            chega_meta;

  assign nivel = {confirma, controle_vertical == CV_DESCE, controle_vertical == CV_SOBE};

  detector_borda #(.WIDTH(3)) u_borda (
    .clk_i   (clock),
    .rst_ni  (reset),
    .nivel_i (nivel),
    .borda_o (borda)
  );

  assign sobe  = borda[0];
  assign desce = borda[1];
  assign conf  = borda[2];

  assign meta       = PW'(META_BASE) * (PW'(modo_q) + PW'(1));
  assign prog_inc   = progresso_q + PW'(1);
  assign chega_meta = tick && (prog_inc == meta);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= INICIAL;
      modo_q      <= '0;
      vidas_q     <= '0;
      progresso_q <= '0;
      timer_q     <= '0;
    end else begin
      estado_q    <= estado_d;
      modo_q      <= modo_d;
      vidas_q     <= vidas_d;
      progresso_q <= progresso_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    modo_d      = modo_q;
    vidas_d     = vidas_q;
    progresso_d = progresso_q;
    timer_d     = timer_q;
    case (estado_q)
      INICIAL: begin
        if (iniciar) begin
          estado_d = ESPERA_MODO;
          modo_d   = '0;
        end
      end
      ESPERA_MODO: begin
        if (conf) begin
          estado_d = ESPERA_VIDAS;
          vidas_d  = VW'(1);
        end else if (sobe) begin
          modo_d = (modo_q == MW'(N_MODOS-1)) ? '0 : modo_q + MW'(1);
        end else if (desce) begin
          modo_d = (modo_q == '0) ? MW'(N_MODOS-1) : modo_q - MW'(1);
        end
      end
      ESPERA_VIDAS: begin
        if (conf) begin
          estado_d    = JOGANDO;
          progresso_d = '0;
        end else if (sobe && vidas_q != VW'(MAX_VIDAS)) begin
          vidas_d = vidas_q + VW'(1);
        end else if (desce && vidas_q > VW'(1)) begin
          vidas_d = vidas_q - VW'(1);
        end
      end
      JOGANDO: begin
        if (tick) progresso_d = prog_inc;
        // A collision outranks a goal-reaching tick in the same cycle.
        if (colisao) begin
          if (vidas_q <= VW'(1)) begin
            vidas_d  = '0;
            estado_d = PERDEU;
          end else begin
            vidas_d  = vidas_q - VW'(1);
            timer_d  = TW'(T_INVULN);
            estado_d = INVULNERAVEL;
          end
        end else if (chega_meta) begin
          estado_d = VENCEU;
        end
      end
      INVULNERAVEL: begin
        if (tick) begin
          progresso_d = prog_inc;
          timer_d     = timer_q - TW'(1);
          if (chega_meta)              estado_d = VENCEU;
          else if (timer_q == TW'(1)) estado_d = JOGANDO;
        end
      end
      VENCEU, PERDEU: begin
        if (iniciar) begin
          estado_d    = ESPERA_MODO;
          modo_d      = '0;
          vidas_d     = '0;
          progresso_d = '0;
        end
      end
      default: estado_d = INICIAL;
    endcase
  end

  assign modo         = modo_q;
  assign vidas        = vidas_q;
  assign progresso    = progresso_q;
  assign jogando      = (estado_q == JOGANDO) || (estado_q == INVULNERAVEL);
  assign invulneravel = (estado_q == INVULNERAVEL);
  assign venceu       = (estado_q == VENCEU);
  assign perdeu       = (estado_q == PERDEU);
  assign db_estado    = estado_q;

endmodule

// File: tb/tb_gerenciador_partida_drone.sv
// Directed bench for gerenciador_partida_drone with default parameters (3 modes, 5 lives, base 32, invuln 8).
module tb_gerenciador_partida_drone;
  import pkg_drone::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [1:0] controle_vertical = CV_NADA;
  logic       confirma = 1'b0;
  logic       tick = 1'b0;
  logic       colisao = 1'b0;
  logic [1:0] modo;
  logic [2:0] vidas;
  logic [6:0] progresso;
  logic       jogando, invulneravel, venceu, perdeu;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;

  gerenciador_partida_drone #(
    .N_MODOS(3), .MAX_VIDAS(5), .META_BASE(32), .T_INVULN(8)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .controle_vertical(controle_vertical), .confirma(confirma),
    .tick(tick), .colisao(colisao), .modo(modo), .vidas(vidas),
    .progresso(progresso), .jogando(jogando), .invulneravel(invulneravel),
    .venceu(venceu), .perdeu(perdeu), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) ciclo();
  endtask

  task automatic cv_edge(input logic [1:0] v);
    controle_vertical = v; ciclo();
    controle_vertical = CV_NADA; ciclo();
  endtask

  task automatic confirmar();
    confirma = 1'b1; ciclo();
    confirma = 1'b0; ciclo();
  endtask

  task automatic pulso_tick();
    tick = 1'b1; ciclo();
    tick = 1'b0;
  endtask

  task automatic iniciar_partida();
    iniciar = 1'b1; ciclo();
    iniciar = 1'b0; ciclo();
  endtask

  task automatic configurar(input int m, input int v);
    for (int i = 0; i < m; i++) cv_edge(CV_SOBE);
    confirmar();
    for (int i = 1; i < v; i++) cv_edge(CV_SOBE);
    confirmar();
  endtask

  task automatic reiniciar();
    reset = 1'b0; step(2);
    reset = 1'b1; ciclo();
  endtask

  initial begin
    step(2);
    chk("rst_estado", db_estado, 0);
    chk("rst_vidas", vidas, 0);
    chk("rst_prog", progresso, 0);
    chk("rst_flags", {jogando, invulneravel, venceu, perdeu}, 0);
    reset = 1'b1; ciclo();

    // Mode selection: held up counts once, then two more edges wrap to 0
    iniciar = 1'b1; ciclo(); iniciar = 1'b0;
    chk("ini_estado", db_estado, 1);
    controle_vertical = CV_SOBE; step(10);
    chk("modo_hold", modo, 1);
    controle_vertical = CV_NADA; ciclo();
    cv_edge(CV_SOBE);
    cv_edge(CV_SOBE);
    chk("modo_wrap_up", modo, 0);
    cv_edge(CV_DESCE);
    chk("modo_wrap_dn", modo, 2);
    confirmar();
    chk("vidas_estado", db_estado, 2);
    chk("vidas_init", vidas, 1);
    chk("modo_conf", modo, 2);

    // Lives selection with saturation both ways
    for (int i = 0; i < 6; i++) cv_edge(CV_SOBE);
    chk("vidas_sat_hi", vidas, 5);
    for (int i = 0; i < 7; i++) cv_edge(CV_DESCE);
    chk("vidas_sat_lo", vidas, 1);
    cv_edge(CV_SOBE); cv_edge(CV_SOBE);
    confirmar();
    chk("vidas_3", vidas, 3);
    chk("jogando_1", jogando, 1);
    chk("jog_estado", db_estado, 3);

    // Asynchronous reset in the middle of gameplay
    reset = 1'b0; #1;
    chk("arst_estado", db_estado, 0);
    chk("arst_vidas", vidas, 0);
    chk("arst_prog", progresso, 0);
    chk("arst_flags", {jogando, invulneravel, venceu, perdeu}, 0);
    step(3);
    chk("arst_hold", db_estado, 0);
    reset = 1'b1; ciclo();

    // Held confirma must not skip ESPERA_VIDAS
    iniciar_partida();
    confirma = 1'b1; step(3);
    chk("conf_held", db_estado, 2);
    confirma = 1'b0; ciclo();
    cv_edge(CV_SOBE); cv_edge(CV_SOBE);
    confirmar();
    chk("m0_estado", db_estado, 3);

    // Invulnerability window of 8 ticks
    colisao = 1'b1; ciclo(); colisao = 1'b0;
    chk("hit_vidas", vidas, 2);
    chk("hit_invuln", invulneravel, 1);
    chk("hit_estado", db_estado, 4);
    for (int i = 0; i < 3; i++) pulso_tick();
    colisao = 1'b1; ciclo(); colisao = 1'b0;
    chk("inv_ignore", vidas, 2);
    for (int i = 0; i < 4; i++) pulso_tick();
    chk("inv_tick7", invulneravel, 1);
    pulso_tick();
    chk("inv_tick8", invulneravel, 0);
    chk("inv_back", db_estado, 3);
    chk("inv_prog", progresso, 8);
    iniciar = 1'b1; ciclo(); iniciar = 1'b0;
    chk("ini_ignored", db_estado, 3);

    // Mode 1 win after 64 ticks
    reiniciar();
    iniciar_partida();
    configurar(1, 2);
    chk("m1_modo", modo, 1);
    for (int i = 0; i < 63; i++) pulso_tick();
    chk("m1_63", db_estado, 3);
    pulso_tick();
    chk("m1_venceu", venceu, 1);
    chk("m1_prog", progresso, 64);
    chk("m1_jog", jogando, 0);
    pulso_tick();
    chk("m1_freeze", progresso, 64);

    // Restart from VENCEU, then tick 64 coincides with a collision
    iniciar = 1'b1; ciclo(); iniciar = 1'b0;
    chk("rs_estado", db_estado, 1);
    chk("rs_vals", {modo, vidas, progresso}, 0);
    ciclo();
    configurar(1, 2);
    for (int i = 0; i < 63; i++) pulso_tick();
    tick = 1'b1; colisao = 1'b1; ciclo(); tick = 1'b0; colisao = 1'b0;
    chk("tie_estado", db_estado, 4);
    chk("tie_venceu", venceu, 0);
    chk("tie_vidas", vidas, 1);
    chk("tie_prog", progresso, 64);

    // Fatal collision with one life, then restart
    reiniciar();
    iniciar_partida();
    configurar(0, 1);
    chk("one_vida", vidas, 1);
    colisao = 1'b1; ciclo(); colisao = 1'b0;
    chk("lose_perdeu", perdeu, 1);
    chk("lose_vidas", vidas, 0);
    chk("lose_estado", db_estado, 6);
    iniciar = 1'b1; ciclo(); iniciar = 1'b0;
    chk("relose_estado", db_estado, 1);
    chk("relose_perdeu", perdeu, 0);
    chk("relose_modo", modo, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
